// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream beat (instr/sel/tag) and downstream
// beat (immediate/tag/error). The block itself uses the slave modport.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [24:0]      INSTR;
    logic [2:0]       IMM_SEL;
    logic [TAG_W-1:0] TAG_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  IMM_OUT;
    logic [TAG_W-1:0] TAG_OUT;
    logic             ERR;

    modport master (
        output IN_VALID, INSTR, IMM_SEL, TAG_IN, OUT_READY,
        input  IN_READY, OUT_VALID, IMM_OUT, TAG_OUT, ERR
    );

    modport slave (
        input  IN_VALID, INSTR, IMM_SEL, TAG_IN, OUT_READY,
        output IN_READY, OUT_VALID, IMM_OUT, TAG_OUT, ERR
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry skid buffer.
// Define IMM_GEN_ZICSR_EN to support CSR_UIMM_TYPE (CSR zimm field, instr[19:15]).
`ifndef U_TYPE
`define U_TYPE          3'd0
`endif
`ifndef J_TYPE
`define J_TYPE          3'd1
`endif
`ifndef S_TYPE
`define S_TYPE          3'd2
`endif
`ifndef B_TYPE
`define B_TYPE          3'd3
`endif
`ifndef I_SIGNED_TYPE
`define I_SIGNED_TYPE   3'd4
`endif
`ifndef I_SHIFT_TYPE
`define I_SHIFT_TYPE    3'd5
`endif
`ifndef I_UNSIGNED_TYPE
`define I_UNSIGNED_TYPE 3'd6
`endif
`ifndef CSR_UIMM_TYPE
`define CSR_UIMM_TYPE   3'd7
`endif

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          FLUSH,
    imm_gen_pipe_if.slave bus
);

    logic [31:7]      ins_s;
    logic [XLEN-1:0]  imm_s;
    logic             err_s;
    logic             accept_s;
    logic             retire_s;
    logic [1:0]       count_nxt_s;

    logic [1:0]       count_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [XLEN-1:0]  head_imm_r;
    logic [TAG_W-1:0] head_tag_r;
    logic             head_err_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_err_r;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r        = v[31] ? {XLEN{1'b1}} : {XLEN{1'b0}};
        r[31:0]  = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r        = {XLEN{1'b0}};
        r[31:0]  = v;
        return r;
    endfunction

    assign ins_s = bus.INSTR;

    // Decode the immediate of the beat currently offered upstream.
    always_comb begin
        imm_s = {XLEN{1'b0}};
        err_s = 1'b0;
        case (bus.IMM_SEL)
            `U_TYPE:          imm_s = sext32({ins_s[31:12], 12'h000});
            `J_TYPE:          imm_s = sext32({{12{ins_s[31]}}, ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0});
            `S_TYPE:          imm_s = sext32({{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]});
            `B_TYPE:          imm_s = sext32({{20{ins_s[31]}}, ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0});
            `I_SIGNED_TYPE:   imm_s = sext32({{20{ins_s[31]}}, ins_s[31:20]});
            `I_UNSIGNED_TYPE: imm_s = zext32({20'h00000, ins_s[31:20]});
            // RV64 shamt carries one extra bit.
            `I_SHIFT_TYPE:    imm_s = (XLEN == 64) ? zext32({26'd0, ins_s[25:20]})
                                                   : zext32({27'd0, ins_s[24:20]});
`ifdef IMM_GEN_ZICSR_EN
            `CSR_UIMM_TYPE:   imm_s = zext32({27'd0, ins_s[19:15]});
`else
            `CSR_UIMM_TYPE: begin
                imm_s = {XLEN{1'b0}};
                err_s = 1'b1;
            end
`endif
            default: begin
                imm_s = {XLEN{1'b0}};
                err_s = 1'b1;
            end
        endcase
    end

    assign accept_s = bus.IN_VALID && in_ready_r;
    assign retire_s = out_valid_r && bus.OUT_READY;

    // Next occupancy from this cycle's accept/retire pair.
    always_comb begin
        count_nxt_s = count_r;
        if (accept_s && !retire_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (retire_s && !accept_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Head/skid storage and registered handshake flags; reset beats flush beats beats traffic.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            head_imm_r  <= {XLEN{1'b0}};
            head_tag_r  <= {TAG_W{1'b0}};
            head_err_r  <= 1'b0;
            skid_imm_r  <= {XLEN{1'b0}};
            skid_tag_r  <= {TAG_W{1'b0}};
            skid_err_r  <= 1'b0;
        end else if (FLUSH) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            in_ready_r  <= (count_nxt_s != 2'd2);
            if (retire_s) begin
                // Full buffer never accepts, so the skid entry simply moves up.
                if (count_r == 2'd2) begin
                    head_imm_r <= skid_imm_r;
                    head_tag_r <= skid_tag_r;
                    head_err_r <= skid_err_r;
                end else if (accept_s) begin
                    head_imm_r <= imm_s;
                    head_tag_r <= bus.TAG_IN;
                    head_err_r <= err_s;
                end
            end else if (accept_s) begin
                if (count_r == 2'd0) begin
                    head_imm_r <= imm_s;
                    head_tag_r <= bus.TAG_IN;
                    head_err_r <= err_s;
                end else begin
                    skid_imm_r <= imm_s;
                    skid_tag_r <= bus.TAG_IN;
                    skid_err_r <= err_s;
                end
            end
        end
    end

    assign bus.IN_READY  = in_ready_r;
    assign bus.OUT_VALID = out_valid_r;
    assign bus.IMM_OUT   = head_imm_r;
    assign bus.TAG_OUT   = head_tag_r;
    assign bus.ERR       = head_err_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// directed vector table, hand-written buffer sequences, then randomized traffic.
`ifndef U_TYPE
`define U_TYPE          3'd0
`endif
`ifndef J_TYPE
`define J_TYPE          3'd1
`endif
`ifndef S_TYPE
`define S_TYPE          3'd2
`endif
`ifndef B_TYPE
`define B_TYPE          3'd3
`endif
`ifndef I_SIGNED_TYPE
`define I_SIGNED_TYPE   3'd4
`endif
`ifndef I_SHIFT_TYPE
`define I_SHIFT_TYPE    3'd5
`endif
`ifndef I_UNSIGNED_TYPE
`define I_UNSIGNED_TYPE 3'd6
`endif
`ifndef CSR_UIMM_TYPE
`define CSR_UIMM_TYPE   3'd7
`endif

module tb_imm_gen_pipe;

    logic CLK = 1'b0;
    logic RESET;
    logic FLUSH;

    always #5 CLK = ~CLK;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .bus(b64.slave));

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [7:0]  tag;
        logic [63:0] e64;
        logic [31:0] e32;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] e64;
        logic [31:0] e32;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [10];
    exp_t q [$];

    // Reference immediate from the architectural field definitions, as plain integers.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel, input int xlen);
        longint v;
        v = 0;
        case (sel)
            `U_TYPE:          v = longint'($signed(ins & 32'hFFFF_F000));
            `I_SIGNED_TYPE:   v = longint'($signed(ins) >>> 20);
            `I_UNSIGNED_TYPE: v = longint'(ins[31:20]);
            `S_TYPE:          v = longint'($signed(ins) >>> 25) * 64'sd32 + longint'(ins[11:7]);
            `B_TYPE: begin
                v = longint'(ins[7]) * 64'sd2048 + longint'(ins[30:25]) * 64'sd32 + longint'(ins[11:8]) * 64'sd2;
                if (ins[31]) v = v - 64'sd4096;
            end
            `J_TYPE: begin
                v = longint'(ins[19:12]) * 64'sd4096 + longint'(ins[20]) * 64'sd2048 + longint'(ins[30:21]) * 64'sd2;
                if (ins[31]) v = v - 64'sd1048576;
            end
            `I_SHIFT_TYPE:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
`ifdef IMM_GEN_ZICSR_EN
            `CSR_UIMM_TYPE:   v = longint'(ins[19:15]);
`endif
            default:          v = 0;
        endcase
        return v;
    endfunction

    function automatic logic ref_err(input logic [2:0] sel);
`ifdef IMM_GEN_ZICSR_EN
        return 1'b0;
`else
        return (sel == `CSR_UIMM_TYPE);
`endif
    endfunction

    function automatic exp_t vec_exp(input vec_t v);
        exp_t e;
        e.e64 = v.e64;
        e.e32 = v.e32;
        e.tag = v.tag;
        e.err = v.err;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag);
        b32.IN_VALID = v;  b32.INSTR = ins[31:7];  b32.IMM_SEL = sel;  b32.TAG_IN = tag;
        b64.IN_VALID = v;  b64.INSTR = ins[31:7];  b64.IMM_SEL = sel;  b64.TAG_IN = tag;
    endtask

    task automatic set_ready(input logic r);
        b32.OUT_READY = r;
        b64.OUT_READY = r;
    endtask

    task automatic chk_head(input string nm, input exp_t e);
        chk({nm, "/valid32"}, 64'(b32.OUT_VALID), 64'd1);
        chk({nm, "/valid64"}, 64'(b64.OUT_VALID), 64'd1);
        chk({nm, "/imm32"},   64'(b32.IMM_OUT),   64'(e.e32));
        chk({nm, "/imm64"},   b64.IMM_OUT,        e.e64);
        chk({nm, "/tag32"},   64'(b32.TAG_OUT),   64'(e.tag));
        chk({nm, "/tag64"},   64'(b64.TAG_OUT),   64'(e.tag));
        chk({nm, "/err32"},   64'(b32.ERR),       64'(e.err));
        chk({nm, "/err64"},   64'(b64.ERR),       64'(e.err));
    endtask

    task automatic chk_flags(input string nm, input logic vld, input logic rdy);
        chk({nm, "/valid32"}, 64'(b32.OUT_VALID), 64'(vld));
        chk({nm, "/valid64"}, 64'(b64.OUT_VALID), 64'(vld));
        chk({nm, "/ready32"}, 64'(b32.IN_READY),  64'(rdy));
        chk({nm, "/ready64"}, 64'(b64.IN_READY),  64'(rdy));
    endtask

    initial begin
        vec_t        t;
        exp_t        e;
        logic [31:0] r_ins;
        logic [2:0]  r_sel;
        logic [7:0]  r_tag;
        logic        r_v, r_rdy, r_fl, acc, ret;

        tbl[0] = '{32'hFFF00093, `I_SIGNED_TYPE,   8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{32'h123452B7, `U_TYPE,          8'h02, 64'h0000_0000_1234_5000, 32'h1234_5000, 1'b0};
        tbl[2] = '{32'hFE000EE3, `B_TYPE,          8'h03, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tbl[3] = '{32'hFFDFF06F, `J_TYPE,          8'h04, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tbl[4] = '{32'hFE112C23, `S_TYPE,          8'h05, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 1'b0};
        tbl[5] = '{32'h03F00013, `I_SHIFT_TYPE,    8'h06, 64'd63,                  32'd31,        1'b0};
        tbl[6] = '{32'hFFF00093, `I_UNSIGNED_TYPE, 8'h07, 64'h0000_0000_0000_0FFF, 32'h0000_0FFF, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
        tbl[7] = '{32'h000F8073, `CSR_UIMM_TYPE,   8'h08, 64'h1F,                  32'h1F,        1'b0};
`else
        tbl[7] = '{32'h000F8073, `CSR_UIMM_TYPE,   8'h08, 64'h0,                   32'h0,         1'b1};
`endif
        tbl[8] = '{32'h800002B7, `U_TYPE,          8'h09, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0};
        tbl[9] = '{32'h00500093, `I_SIGNED_TYPE,   8'h0A, 64'd5,                   32'd5,         1'b0};

        // Reset state
        RESET = 1'b1;
        FLUSH = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        set_ready(1'b0);
        tick();
        tick();
        RESET = 1'b0;
        chk_flags("reset", 1'b0, 1'b1);
        chk("reset/imm32", 64'(b32.IMM_OUT), 64'd0);
        chk("reset/imm64", b64.IMM_OUT, 64'd0);
        chk("reset/tag", 64'(b32.TAG_OUT), 64'd0);
        chk("reset/err", 64'(b32.ERR), 64'd0);

        // Directed vectors: one beat each, visible one cycle after accept
        set_ready(1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].ins, tbl[i].sel, tbl[i].tag);
            tick();
            drive(1'b0, 32'h0, 3'd0, 8'h00);
            chk_head($sformatf("vec%0d", i), vec_exp(tbl[i]));
            tick();
            chk_flags($sformatf("vec%0d_drain", i), 1'b0, 1'b1);
        end

        // Back-to-back beats keep order (tags 0x11 then 0x22)
        t = tbl[1]; t.tag = 8'h11;
        drive(1'b1, t.ins, t.sel, t.tag);
        tick();
        chk_head("order1", vec_exp(t));
        t = tbl[2]; t.tag = 8'h22;
        drive(1'b1, t.ins, t.sel, t.tag);
        tick();
        chk_head("order2", vec_exp(t));
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        tick();
        chk_flags("order_idle", 1'b0, 1'b1);

        // Backpressure: two accepts fill the buffer, third beat held upstream
        set_ready(1'b0);
        drive(1'b1, tbl[3].ins, tbl[3].sel, tbl[3].tag);
        tick();
        chk_flags("bp_one", 1'b1, 1'b1);
        drive(1'b1, tbl[4].ins, tbl[4].sel, tbl[4].tag);
        tick();
        chk_flags("bp_full", 1'b1, 1'b0);
        drive(1'b1, tbl[5].ins, tbl[5].sel, tbl[5].tag);
        tick();
        chk_flags("bp_hold", 1'b1, 1'b0);
        chk_head("bp_stable", vec_exp(tbl[3]));
        set_ready(1'b1);
        #1;
        chk_flags("bp_no_comb_ready", 1'b1, 1'b0);
        tick();
        chk_head("bp_ret2", vec_exp(tbl[4]));
        chk_flags("bp_ret2f", 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        chk_head("bp_ret3", vec_exp(tbl[5]));
        tick();
        chk_flags("bp_empty", 1'b0, 1'b1);

        // Flush while full, with a beat offered in the same cycle
        set_ready(1'b0);
        drive(1'b1, tbl[6].ins, tbl[6].sel, tbl[6].tag);
        tick();
        drive(1'b1, tbl[7].ins, tbl[7].sel, tbl[7].tag);
        tick();
        chk_flags("fl_full", 1'b1, 1'b0);
        drive(1'b1, tbl[8].ins, tbl[8].sel, tbl[8].tag);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        chk_flags("fl_after", 1'b0, 1'b1);
        set_ready(1'b1);
        tick();
        chk_flags("fl_nothing", 1'b0, 1'b1);

        // Reset mid-stream drops everything and restores reset values
        set_ready(1'b0);
        drive(1'b1, tbl[7].ins, tbl[7].sel, tbl[7].tag);
        tick();
        drive(1'b1, tbl[0].ins, tbl[0].sel, tbl[0].tag);
        tick();
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_flags("rst_mid", 1'b0, 1'b1);
        chk("rst_mid/imm64", b64.IMM_OUT, 64'd0);
        chk("rst_mid/tag", 64'(b64.TAG_OUT), 64'd0);
        chk("rst_mid/err", 64'(b64.ERR), 64'd0);

        // Randomized traffic against a queue model of the buffer
        q.delete();
        for (int c = 0; c < 600; c++) begin
            r_ins = $urandom();
            r_sel = 3'($urandom_range(0, 7));
            r_tag = 8'($urandom());
            r_v   = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_fl  = ($urandom_range(0, 24) == 0);
            drive(r_v, r_ins, r_sel, r_tag);
            set_ready(r_rdy);
            FLUSH = r_fl;
            #1;
            chk_flags("rnd", q.size() > 0, q.size() < 2);
            if (q.size() > 0) chk_head("rnd_head", q[0]);
            acc = r_v && (q.size() < 2);
            ret = r_rdy && (q.size() > 0);
            tick();
            if (r_fl) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) begin
                    e.e64 = ref_imm(r_ins, r_sel, 64);
                    e.e32 = 32'(ref_imm(r_ins, r_sel, 32));
                    e.tag = r_tag;
                    e.err = ref_err(r_sel);
                    q.push_back(e);
                end
            end
        end
        FLUSH = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
